// File: rtl/tpm_fifo_regs.sv
// tpm_fifo_regs: locality-0 TPM FIFO register file behind the SPI TPM peripheral.
// Define TPM_FIFO_REGS_RID_EN to map TPM_RID at 0x0F04.

module tpm_fifo_regs_fifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic [AW:0]   count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign do_push = push & (count != (AW+1)'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

module tpm_fifo_regs #(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] DID_VID = 32'h0001_1D50,
  parameter logic [7:0]  RID     = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        data_wr_i,
  output logic        wr_done_o,
  input  logic        data_req_i,
  output logic [7:0]  rdata_o,
  output logic        data_rd_o,
  output logic [7:0]  cmd_data_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  input  logic [7:0]  resp_data_i,
  input  logic        resp_valid_i,
  output logic        resp_ready_o,
  output logic        go_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOOKUP, PRESENT, RETIRE} state_t;
  state_t state_q, state_d;

  logic [2:0]  wr_sync, req_sync;
  logic        wr_rise, req_rise, req_fall;
  logic        active, cmd_rdy, pop_pend, rd_pop;
  logic [AW:0] cmd_cnt, resp_cnt;
  logic        cmd_full, cmd_empty, resp_full, resp_empty;
  logic [7:0]  resp_head, rd_byte;
  logic [15:0] burst;
  logic        is_access, is_sts, is_data;
  logic        wr_access, wr_sts, wr_data, flush;

  // Two synchroniser stages, third bit is the edge-detect history
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_sync  <= '0;
      req_sync <= '0;
    end else begin
      wr_sync  <= {wr_sync[1:0], data_wr_i};
      req_sync <= {req_sync[1:0], data_req_i};
    end
  end

  assign wr_rise  = wr_sync[1] & ~wr_sync[2];
  assign req_rise = req_sync[1] & ~req_sync[2];
  assign req_fall = ~req_sync[1] & req_sync[2];

  assign is_access = (addr_i == 16'h0000);
  assign is_sts    = (addr_i == 16'h0018);
  assign is_data   = (addr_i[15:2] == 14'h0009);

  assign wr_access = wr_rise & is_access;
  assign wr_sts    = wr_rise & is_sts & active;
  assign wr_data   = wr_rise & is_data & active;
  assign flush     = wr_sts & wdata_i[6];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active    <= 1'b0;
      cmd_rdy   <= 1'b0;
      go_o      <= 1'b0;
      wr_done_o <= 1'b0;
    end else begin
      go_o <= wr_sts & wdata_i[5] & ~wdata_i[6];
      if (wr_rise)          wr_done_o <= 1'b1;
      else if (!wr_sync[1]) wr_done_o <= 1'b0;
      if (wr_access && wdata_i[5]) begin
        active  <= 1'b0;
        cmd_rdy <= 1'b0;
      end else if (wr_access && wdata_i[1]) begin
        active  <= 1'b1;
      end else if (wr_sts && wdata_i[6]) begin
        cmd_rdy <= 1'b1;
      end else if (wr_sts && wdata_i[5]) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  tpm_fifo_regs_fifo #(.DEPTH(DEPTH)) u_cmd (
    .clk(clk_i), .rst_n(rst_n_i),
    .push(wr_data), .wdata(wdata_i),
    .pop(cmd_valid_o & cmd_ready_i), .flush(flush),
    .head(cmd_data_o), .count(cmd_cnt)
  );

  tpm_fifo_regs_fifo #(.DEPTH(DEPTH)) u_resp (
    .clk(clk_i), .rst_n(rst_n_i),
    .push(resp_valid_i & resp_ready_o), .wdata(resp_data_i),
    .pop(rd_pop), .flush(flush),
    .head(resp_head), .count(resp_cnt)
  );

  assign cmd_full     = (cmd_cnt == (AW+1)'(DEPTH));
  assign cmd_empty    = (cmd_cnt == '0);
  assign resp_full    = (resp_cnt == (AW+1)'(DEPTH));
  assign resp_empty   = (resp_cnt == '0);
  assign cmd_valid_o  = ~cmd_empty;
  assign resp_ready_o = ~resp_full;
  assign burst        = 16'(DEPTH) - 16'(cmd_cnt);

  always_comb begin
    rd_byte = 8'hFF;
    case (addr_i)
      16'h0000: rd_byte = {1'b1, 1'b0, active, 4'b0000, 1'b1};
      16'h0018: rd_byte = {1'b1, cmd_rdy, 1'b0, ~resp_empty, ~cmd_empty & ~cmd_full, 3'b000};
      16'h0019: rd_byte = burst[7:0];
      16'h001A: rd_byte = burst[15:8];
      16'h0024, 16'h0025,
      16'h0026, 16'h0027: rd_byte = resp_empty ? 8'hFF : resp_head;
      16'h0F00: rd_byte = DID_VID[7:0];
      16'h0F01: rd_byte = DID_VID[15:8];
      16'h0F02: rd_byte = DID_VID[23:16];
      16'h0F03: rd_byte = DID_VID[31:24];
`ifdef TPM_FIFO_REGS_RID_EN
      16'h0F04: rd_byte = RID;
`else
      // Unmapped without the feature; the OR keeps the result at FF
      16'h0F04: rd_byte = 8'hFF | RID;
`endif
      default:  rd_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_rise) state_d = LOOKUP;
      LOOKUP:  state_d = req_fall ? RETIRE : PRESENT;
      PRESENT: if (!req_sync[1]) state_d = RETIRE;
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_rd_o = (state_q == PRESENT);
    rd_pop    = (state_q == RETIRE) & pop_pend;
  end

  // Pop decision is frozen at lookup so the popped byte is the one presented
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o  <= 8'hFF;
      pop_pend <= 1'b0;
    end else if (state_q == LOOKUP) begin
      rdata_o  <= rd_byte;
      pop_pend <= is_data & active & ~resp_empty;
    end
  end
endmodule

// File: doc/tpm_fifo_regs.md
Name: tpm_fifo_regs

Overview:
- Data provider behind the SPI TPM peripheral: consumes its write strobes and serves its read requests.
- Implements the locality-0 subset of the TPM FIFO register map, with a command FIFO toward the TPM core and a response FIFO from it.
- Runs on the system clock and synchronises the peripheral's SPI-clock-domain handshake signals internally.

Parameters:
- DEPTH, 64, entries per FIFO; power of two, at least 4.
- DID_VID, 32'h0001_1D50, value returned by TPM_DID_VID at 0x0F00..0x0F03, little-endian.
- RID, 8'h00, value of TPM_RID; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- addr_i  in  16  register address from the peripheral.
- wdata_i  in  8  write data from the peripheral.
- data_wr_i  in  1  write strobe from the peripheral (SPI domain).
- wr_done_o  out  1  write consumed.
- data_req_i  in  1  read request from the peripheral (SPI domain); rise means request, fall means byte taken.
- rdata_o  out  8  read data to the peripheral.
- data_rd_o  out  1  rdata_o valid.
- cmd_data_o  out  8  command FIFO head.
- cmd_valid_o  out  1  command FIFO not empty.
- cmd_ready_i  in  1  core pops the command FIFO.
- resp_data_i  in  8  response byte from the core.
- resp_valid_i  in  1  core pushes a response byte.
- resp_ready_o  out  1  response FIFO not full.
- go_o  out  1  one-cycle pulse on a tpmGo write.

Behaviour:
- Reset values:
  - wr_done_o, data_rd_o, go_o, cmd_valid_o: 0.
  - rdata_o: 8'hFF.
  - resp_ready_o: 1.
  - Both FIFOs empty; locality inactive; commandReady 0.
- Synchronisation:
  - data_wr_i and data_req_i each pass through a 2-FF synchroniser followed by an edge-detect register.
  - addr_i and wdata_i are sampled unsynchronised on a synchronised edge; they are stable for the whole handshake.
- Write path:
  - The register write takes effect in cycle 3 after the data_wr_i rise.
  - wr_done_o rises in that same cycle and stays high until synchronised data_wr_i is low.
- Read path: handshake FSM with states IDLE, LOOKUP, PRESENT, RETIRE.
  - IDLE: wait for the synchronised data_req_i rise.
  - LOOKUP: decode addr_i and register the result into rdata_o.
  - PRESENT: data_rd_o=1, rdata_o held; wait for the synchronised data_req_i fall.
  - RETIRE: data_rd_o=0, then apply the read side effect (DATA_FIFO pop); return to IDLE.
  - data_rd_o rises 4 cycles after the data_req_i rise.
  - A request fall seen in LOOKUP still passes through RETIRE.
- Address decode (address bits [15:12] must be 0; anything else reads 8'hFF and ignores writes):
  - 0x0000 ACCESS.
    - Read: bit7=1 (regValid), bit5=active, bit0=1; all other bits 0.
    - Write bit1=1: active<=1.
    - Write bit5=1: active<=0, clearing commandReady.
  - 0x0018 STS byte 0.
    - Read: bit7=1 (stsValid), bit6=commandReady, bit4=dataAvail (response FIFO non-empty), bit3=Expect (command FIFO non-empty and not full); all other bits 0.
    - Write bit6=1: flush both FIFOs, commandReady<=1.
    - Write bit5=1: go_o pulse, commandReady<=0.
    - Bit6 and bit5 both set in one write: flush only, no go_o pulse.
  - 0x0019/0x001A burstCount, little-endian 16-bit.
    - Value is DEPTH minus command FIFO occupancy, zero-extended.
  - 0x0024..0x0027 DATA_FIFO.
    - Write pushes wdata_i.
    - Read returns the response FIFO head, popped in RETIRE.
    - Read with the response FIFO empty returns 8'hFF with no pop.
  - 0x0F00..0x0F03 DID_VID: returns the byte at offset addr_i[1:0].
  - Other addresses: reads 8'hFF; writes ignored.
- Locality gating:
  - While active=0, writes to STS and DATA_FIFO are ignored and DATA_FIFO reads do not pop.
  - ACCESS and DID_VID are always accessible.
- FIFOs:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Push to a full FIFO is dropped without changing state.
  - Pop from an empty FIFO is a no-op.
  - Push and pop in the same cycle keep the count unchanged.
  - A flush in the same cycle as a push or pop wins: the FIFO ends empty.
  - The core side pops the command FIFO when cmd_valid_o & cmd_ready_i.
  - The response FIFO accepts a byte when resp_valid_i & resp_ready_o.
- Reset mid-transfer:
  - All state clears at once, FSM returns to IDLE, data_rd_o and wr_done_o drop.
  - Synchroniser flops reset to 0, so a strobe still high after reset release is seen as a fresh edge.

Optional Feature:
- TPM_FIFO_REGS_RID_EN defined: address 0x0F04 (TPM_RID) reads the RID parameter; writes are ignored.
- Undefined: 0x0F04 reads 8'hFF like any other unmapped address, and the RID parameter is unused.

Test Plan:
- Reset, then read 0x0000 -> 8'h81; read 0x0F00..0x0F03 -> 50,1D,01,00; data_rd_o rises 4 clocks after data_req_i.
- Write 0x0000=8'h02, then write 0x0018=8'h40 -> ACCESS reads 8'hA1; STS reads 8'hC0; burstCount 0x0019/0x001A reads 64/0.
- Active, write 0x0024 three times with AA, BB, CC -> cmd_data_o shows AA, BB, CC in order; STS bit3=1; burstCount reads 61; write STS=8'h20 -> exactly one go_o pulse.
- Core pushes 11, 22; host reads 0x0024 three times -> 11, 22, FF; STS bit4 goes 1, 1, 0; pop occurs only after the data_req_i fall.
- Fill the command FIFO with DEPTH+1 writes -> count stays DEPTH, extra byte dropped, burstCount=0; write STS=8'h40 -> both FIFOs empty.
- Assert rst_n_i while data_rd_o=1 -> data_rd_o=0 and rdata_o=FF immediately; with the macro defined, read 0x0F04 -> RID; without it -> FF.
